// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core loop controller.
// Optional feature macro: LOOP_CTRL_STACK_CHECK_EN (stack overflow/underflow
// detection and the ERROR state).
package bf_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SKIP  = 2'd1,
    ERROR = 2'd2
  } loop_state_t;

  // Instruction encodings of the loop brackets.
  localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'

endpackage

// File: rtl/loop_stack.sv
// Return-address LIFO for loop_ctrl. The pointer wraps modulo DEPTH, so a
// push on a full stack overwrites the oldest slot and a pop on an empty stack
// wraps; the occupancy count saturates and drives full/empty. Reset clears
// pointer and count only, never the storage.
module loop_stack #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] data_i,
  output logic [ADDR_WIDTH-1:0] top_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW:0]           cnt_q, cnt_d;

  // Next pointer and saturating occupancy count.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + IW'(1);
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + (IW+1)'(1);
    end else if (pop_i) begin
      ptr_d = ptr_q - IW'(1);
      if (cnt_q != '0) cnt_d = cnt_q - (IW+1)'(1);
    end
  end

  // Pointer and count registers, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= data_i;
  end

  assign top_o   = mem_q[ptr_q - IW'(1)];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/loop_ctrl.sv
// Loop controller: tracks '['/']' nesting, keeps loop return addresses on a
// LIFO and drives enable/load/data of the PC counter in the same cycle as the
// instruction. Optional macro LOOP_CTRL_STACK_CHECK_EN adds overflow/underflow
// detection with a terminal ERROR state; without it the stack simply wraps.
module loop_ctrl
  import bf_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  insn_valid_i,
  input  logic                  insn_open_i,
  input  logic                  insn_close_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  cell_zero_i,
  output logic                  pc_ce_o,
  output logic                  pc_load_o,
  output logic [ADDR_WIDTH-1:0] pc_d_o,
  output logic                  skipping_o,
  output logic                  stack_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  loop_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] depth_q, depth_d;
  logic                  skip_q;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] stk_top;
  logic                  stk_full, stk_empty;
  logic                  is_open, is_close;

  // Both brackets high at once is treated as a plain instruction.
  assign is_open  = insn_valid_i &  insn_open_i & ~insn_close_i;
  assign is_close = insn_valid_i & ~insn_open_i &  insn_close_i;

`ifdef LOOP_CTRL_STACK_CHECK_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
`else
  logic unused_full;
  assign unused_full = stk_full;
`endif

  loop_stack #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_stack (
    .clk_i  (clk_i),
    .rst_ni (reset_ni),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_i),
    .top_o  (stk_top),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );

  // Mealy decision: PC controls, stack ops and next state from this instruction.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    push      = 1'b0;
    pop       = 1'b0;
    pc_ce_o   = insn_valid_i;
    pc_load_o = 1'b0;
    pc_d_o    = '0;
`ifdef LOOP_CTRL_STACK_CHECK_EN
    ovf_d     = ovf_q;
    unf_d     = unf_q;
`endif
    case (state_q)
      RUN: begin
        if (is_open) begin
          if (!cell_zero_i) begin
`ifdef LOOP_CTRL_STACK_CHECK_EN
            if (stk_full) begin
              ovf_d   = 1'b1;
              state_d = ERROR;
              pc_ce_o = 1'b0;
            end else begin
              push = 1'b1;
            end
`else
            push = 1'b1;
`endif
          end else begin
            // Zero cell: walk over the loop body; this '[' is depth 1.
            depth_d = ADDR_WIDTH'(1);
            state_d = SKIP;
          end
        end else if (is_close) begin
`ifdef LOOP_CTRL_STACK_CHECK_EN
          if (stk_empty) begin
            unf_d   = 1'b1;
            state_d = ERROR;
            pc_ce_o = 1'b0;
          end else
`endif
          if (!cell_zero_i) begin
            // Jump back to the instruction after the matching '['.
            pc_load_o = 1'b1;
            pc_d_o    = stk_top + ADDR_WIDTH'(1);
          end else begin
            pop = 1'b1;
          end
        end
      end
      SKIP: begin
        if (is_open) begin
          depth_d = depth_q + ADDR_WIDTH'(1);
        end else if (is_close) begin
          if (depth_q == ADDR_WIDTH'(1)) begin
            state_d = RUN;
            depth_d = '0;
          end else begin
            depth_d = depth_q - ADDR_WIDTH'(1);
          end
        end
      end
      default: begin
        // ERROR: frozen until reset.
        pc_ce_o = 1'b0;
      end
    endcase
  end

  // FSM state, skip depth and registered status outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RUN;
      depth_q <= '0;
      skip_q  <= 1'b0;
`ifdef LOOP_CTRL_STACK_CHECK_EN
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      skip_q  <= (state_d == SKIP);
`ifdef LOOP_CTRL_STACK_CHECK_EN
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`endif
    end
  end

  assign skipping_o    = skip_q;
  assign stack_empty_o = stk_empty;
`ifdef LOOP_CTRL_STACK_CHECK_EN
  assign overflow_o    = ovf_q;
  assign underflow_o   = unf_q;
`else
  assign overflow_o    = 1'b0;
  assign underflow_o   = 1'b0;
`endif

endmodule

// File: tb/tb_loop_ctrl.sv
// Directed bench for loop_ctrl (DEPTH=4). Expectations for each step are
// queued when the step is driven and compared when the outputs settle.
module tb_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, opn = 1'b0, cls = 1'b0, cz = 1'b0;
  logic [7:0] pc = '0;
  logic       pc_ce, pc_load, skipping, stack_empty, overflow, underflow;
  logic [7:0] pc_d;

  int total = 0;
  int bad   = 0;
  int stepn = 0;

  typedef struct {
    logic       ce;
    logic       ld;
    logic [7:0] d;
    logic       sk;
    logic       em;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  loop_ctrl #(
    .ADDR_WIDTH(8),
    .DEPTH     (4)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .insn_valid_i (valid),
    .insn_open_i  (opn),
    .insn_close_i (cls),
    .pc_i         (pc),
    .cell_zero_i  (cz),
    .pc_ce_o      (pc_ce),
    .pc_load_o    (pc_load),
    .pc_d_o       (pc_d),
    .skipping_o   (skipping),
    .stack_empty_o(stack_empty),
    .overflow_o   (overflow),
    .underflow_o  (underflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepn, obs, exp_v);
    end
  endtask

  // Drive one instruction (called at a falling edge), check outputs before the
  // next rising edge, then advance to the following falling edge.
  task automatic step(input logic v, input logic o, input logic c, input logic [7:0] p,
                      input logic z, input logic ece, input logic eld, input logic [7:0] ed,
                      input logic esk, input logic eem, input logic eov, input logic eun);
    exp_t e;
    valid = v; opn = o; cls = c; pc = p; cz = z;
    e = '{ce: ece, ld: eld, d: ed, sk: esk, em: eem, ov: eov, un: eun};
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk("pc_ce",       {7'd0, pc_ce},       {7'd0, e.ce});
    chk("pc_load",     {7'd0, pc_load},     {7'd0, e.ld});
    chk("pc_d",        pc_d,                e.d);
    chk("skipping",    {7'd0, skipping},    {7'd0, e.sk});
    chk("stack_empty", {7'd0, stack_empty}, {7'd0, e.em});
    chk("overflow",    {7'd0, overflow},    {7'd0, e.ov});
    chk("underflow",   {7'd0, underflow},   {7'd0, e.un});
    stepn++;
    @(negedge clk);
  endtask

  // Assert reset, confirm reset values while low, release at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    // Reset state.
    step(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0, 0);
    rst_n = 1'b1;

    // '[' at 3 with cell!=0, ']' at 7 jumps to 4, then ']' with cell=0 pops.
    step(1, 1, 0, 8'd3, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    step(1, 0, 1, 8'd7, 0, 1, 1, 8'd4, 0, 0, 0, 0);
    step(1, 0, 1, 8'd7, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd8, 0, 0, 0, 8'd0, 0, 1, 0, 0);

    // "[ [ ] + ]" from pc=2 with cell=0: skipped body, no pushes, no loads.
    step(1, 1, 0, 8'd2, 1, 1, 0, 8'd0, 0, 1, 0, 0);
    step(1, 1, 0, 8'd3, 1, 1, 0, 8'd0, 1, 1, 0, 0);
    step(1, 0, 1, 8'd4, 0, 1, 0, 8'd0, 1, 1, 0, 0);
    step(1, 0, 0, 8'd5, 1, 1, 0, 8'd0, 1, 1, 0, 0);
    step(1, 0, 1, 8'd6, 1, 1, 0, 8'd0, 1, 1, 0, 0);
    step(1, 0, 0, 8'd7, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    // Open and close together: plain advance, no push.
    step(1, 1, 1, 8'd8, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    step(0, 0, 0, 8'd9, 0, 0, 0, 8'd0, 0, 1, 0, 0);

    // insn_valid low with brackets toggling leaves stack and state alone.
    step(1, 1, 0, 8'd10, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, i[0], ~i[0], 8'(i), i[1], 0, 0, 8'd0, 0, 0, 0, 0);
    end
    step(1, 0, 1, 8'd12, 0, 1, 1, 8'd11, 0, 0, 0, 0);
    step(1, 0, 1, 8'd12, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd13, 0, 0, 0, 8'd0, 0, 1, 0, 0);

    // Reset while skipping at depth 3 clears everything without a clock edge.
    step(1, 1, 0, 8'd0, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    step(1, 1, 0, 8'd1, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 1, 0, 8'd2, 1, 1, 0, 8'd0, 1, 0, 0, 0);
    step(1, 1, 0, 8'd3, 1, 1, 0, 8'd0, 1, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 8'd0, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    step(1, 0, 1, 8'd5, 0, 1, 1, 8'd1, 0, 0, 0, 0);
    step(1, 0, 1, 8'd5, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd6, 0, 0, 0, 8'd0, 0, 1, 0, 0);

    // Four pushes fill the stack; the fifth is the boundary case.
    step(1, 1, 0, 8'd20, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    step(1, 1, 0, 8'd21, 0, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 1, 0, 8'd22, 0, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 1, 0, 8'd23, 0, 1, 0, 8'd0, 0, 0, 0, 0);
`ifdef LOOP_CTRL_STACK_CHECK_EN
    step(1, 1, 0, 8'd24, 0, 0, 0, 8'd0, 0, 0, 0, 0);
    step(1, 0, 0, 8'd25, 0, 0, 0, 8'd0, 0, 0, 1, 0);
    step(1, 0, 1, 8'd26, 0, 0, 0, 8'd0, 0, 0, 1, 0);
    do_reset();
    // ']' on an empty stack, both cell values.
    step(1, 0, 1, 8'd9, 0, 0, 0, 8'd0, 0, 1, 0, 0);
    step(1, 0, 0, 8'd10, 0, 0, 0, 8'd0, 0, 1, 0, 1);
    do_reset();
    step(1, 0, 1, 8'd9, 1, 0, 0, 8'd0, 0, 1, 0, 0);
    step(1, 0, 0, 8'd10, 0, 0, 0, 8'd0, 0, 1, 0, 1);
    do_reset();
`else
    // Fifth push overwrites the oldest slot and becomes the top.
    step(1, 1, 0, 8'd24, 0, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 0, 1, 8'd30, 0, 1, 1, 8'd25, 0, 0, 0, 0);
    step(1, 0, 1, 8'd31, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 0, 1, 8'd32, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 0, 1, 8'd33, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(1, 0, 1, 8'd34, 1, 1, 0, 8'd0, 0, 0, 0, 0);
    step(0, 0, 0, 8'd35, 0, 0, 0, 8'd0, 0, 1, 0, 0);
    do_reset();
    // ']' on an empty stack jumps to the wrapped slot (holding 23) + 1.
    step(1, 0, 1, 8'd9, 0, 1, 1, 8'd24, 0, 1, 0, 0);
    step(1, 0, 1, 8'd10, 1, 1, 0, 8'd0, 0, 1, 0, 0);
    step(1, 0, 0, 8'd11, 0, 1, 0, 8'd0, 0, 1, 0, 0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
